timer_sequencer: RTL and testbench
==================================

// Module: timer_sequencer
// PURPOSE
//  Avalon-MM master that owns the interval timer slave (16-bit regs: 0 status, 1 control, 2 period_l, 3 period_h).
//  On a start request it programs the period, starts the timer continuous with IRQ enabled and verifies RUN.
//  It then services each timeout IRQ by clearing status, pulsing tick, and stops the timer after N ticks.
//  Sits between application logic and the timer, in place of Nios software driving it.
// PARAMETERS
//  MIN_PERIOD  3   smallest accepted cfg_period; lower values are clamped to MIN_PERIOD.
// PORTS
//  clk            in   1   system clock; the only clock.
//  reset          in   1   synchronous, active-high reset.
//  cfg_start      in   1   1-cycle request to begin; sampled only in IDLE.
//  cfg_abort      in   1   level; stop the timer and return to IDLE.
//  cfg_period     in   32  timer reload value; sampled with cfg_start.
//  cfg_count      in   16  ticks before auto-stop; 0 = run until abort. Sampled with cfg_start.
//  av_address     out  3   timer register address.
//  av_chipselect  out  1   timer select.
//  av_write_n     out  1   active-low write strobe.
//  av_writedata   out  16  write data.
//  av_readdata    in   16  timer read data; registered in the timer, valid 1 cycle after the address.
//  timer_irq      in   1   timer interrupt: timeout flag AND interrupt enable.
//  busy           out  1   high in every state except IDLE.
//  tick           out  1   1-cycle pulse per serviced timeout.
//  tick_count     out  16  timeouts serviced since the last start; wraps at 16'hFFFF.
//  done           out  1   1-cycle pulse on completion, abort or error.
//  err            out  1   sticky; RUN bit missing after start. Cleared by the next accepted cfg_start.
// BEHAVIOUR
//  Reset values: FSM=IDLE, av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0, busy=0, tick=0,
//   tick_count=0, done=0, err=0. All outputs are registered.
//  The timer has no waitrequest, so each bus access lasts exactly 1 cycle.
//  Write cycle: chipselect=1, write_n=0. Read cycle: chipselect=1, write_n=1.
//  Bus idles with chipselect=0 and write_n=1 whenever no access is issued.
//  FSM, one state per cycle unless noted:
//   IDLE     on cfg_start: latch max(cfg_period,MIN_PERIOD) and cfg_count; clear tick_count and err -> WR_PL.
//   WR_PL    write addr 2 = period[15:0] -> WR_PH.
//   WR_PH    write addr 3 = period[31:16] -> WR_CTRL.
//   WR_CTRL  write addr 1 = 16'h0007 (ITO|CONT|START) -> RD_STAT.
//   RD_STAT  read addr 0 -> CHK.
//   CHK      av_readdata[1]=1 -> RUN; otherwise set err -> STOP.
//   RUN      wait for timer_irq=1 -> CLR.
//   CLR      write addr 0 = 16'h0000; pulse tick; tick_count+1.
//            If cfg_count!=0 and the new tick_count==cfg_count -> STOP, else -> RUN.
//   STOP     write addr 1 = 16'h0008 (STOP, ITO=0) -> DONE.
//   DONE     pulse done -> IDLE.
//  Latency: cfg_start to first timer write = 1 cycle. timer_irq high to status-clear write = 1 cycle.
//   The timer drops irq the cycle after CLR, so RUN never re-services the same timeout.
//  cfg_abort has priority over every other transition in WR_PL..CLR: next state is STOP.
//   A CLR in progress still completes its write and tick.
//   In STOP, DONE or IDLE, cfg_abort is ignored.
//  cfg_start while busy is ignored; the latched config is held.
//  cfg_count=1: auto-stop after the first tick.
//  tick_count wrap with cfg_count=0 is legal and does not stop the timer.
//  Reset mid-operation forces IDLE next cycle and issues no STOP write.
//   The timer is reset by the same system reset.
// TESTING
//  T1 cfg_period=99, cfg_count=3 -> writes (2,0x0063) (3,0x0000) (1,0x0007); read addr 0; 3 ticks;
//     tick_count=3; write (1,0x0008); done pulses once; busy=0.
//  T2 cfg_period=32'h0001_86A0, cfg_count=0; abort after 5 ticks -> writes (2,0x86A0) (3,0x0001);
//     tick_count=5; STOP write; done.
//  T3 slave model returns status bit1=0 at CHK -> err=1; write (1,0x0008); done;
//     the next cfg_start clears err.
//  T4 cfg_period=1 -> period_l written as 0x0003. cfg_start pulsed during RUN -> ignored,
//     no extra bus traffic.
//  T5 timer_irq asserted on the same cycle as cfg_abort in RUN -> STOP, no tick.
//     cfg_abort in CLR -> tick emitted, then STOP.
//  T6 reset asserted in RUN -> next cycle all outputs at reset values; bus idle, no write issued.

Source files
------------

// File: rtl/timer_sequencer.sv
// timer_sequencer: Avalon-MM master that programs the interval timer, services its IRQ with tick pulses and stops it after cfg_count ticks or on abort.
module timer_sequencer #(
  parameter int MIN_PERIOD = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [31:0] cfg_period,
  input  logic [15:0] cfg_count,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        timer_irq,
  output logic        busy,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic        done,
  output logic        err
);
  typedef enum logic [3:0] {IDLE, WR_PL, WR_PH, WR_CTRL, RD_STAT, CHK, RUN, CLR, STOP, DONE} state_t;
  state_t state, state_n;
  logic [31:0] period_q, period_n;
  logic [15:0] count_q;
  logic accept, abort_ok, wr, rd;
  logic [2:0] addr_n;
  logic [15:0] data_n;
  always_comb begin
    accept = state == IDLE && cfg_start;
    abort_ok = cfg_abort && state inside {WR_PL, WR_PH, WR_CTRL, RD_STAT, CHK, RUN, CLR};
    period_n = !accept ? period_q : cfg_period < 32'(MIN_PERIOD) ? 32'(MIN_PERIOD) : cfg_period;
    state_n = state;
    case (state)
      IDLE:    state_n = cfg_start ? WR_PL : IDLE;
      WR_PL:   state_n = WR_PH;
      WR_PH:   state_n = WR_CTRL;
      WR_CTRL: state_n = RD_STAT;
      RD_STAT: state_n = CHK;
      CHK:     state_n = av_readdata[1] ? RUN : STOP;
      RUN:     state_n = timer_irq ? CLR : RUN;
      CLR:     state_n = (count_q != 16'd0 && tick_count == count_q) ? STOP : RUN;
      STOP:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (abort_ok) state_n = STOP;
    wr = state_n inside {WR_PL, WR_PH, WR_CTRL, CLR, STOP};
    rd = state_n == RD_STAT;
    addr_n = state_n == WR_PL ? 3'd2 : state_n == WR_PH ? 3'd3 : state_n inside {WR_CTRL, STOP} ? 3'd1 : 3'd0;
    data_n = state_n == WR_PL ? period_n[15:0] : state_n == WR_PH ? period_q[31:16] :
             state_n == WR_CTRL ? 16'h0007 : state_n == STOP ? 16'h0008 : 16'h0000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      period_q <= '0;
      count_q <= '0;
      av_address <= '0;
      av_chipselect <= 1'b0;
      av_write_n <= 1'b1;
      av_writedata <= '0;
      busy <= 1'b0;
      tick <= 1'b0;
      tick_count <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      period_q <= period_n;
      count_q <= accept ? cfg_count : count_q;
      av_address <= addr_n;
      av_chipselect <= wr || rd;
      av_write_n <= !wr;
      av_writedata <= data_n;
      busy <= state_n != IDLE;
      tick <= state_n == CLR;
      tick_count <= accept ? 16'd0 : state_n == CLR ? tick_count + 16'd1 : tick_count;
      done <= state_n == DONE;
      err <= accept ? 1'b0 : (state == CHK && !av_readdata[1] && !cfg_abort) ? 1'b1 : err;
    end
  end
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: randomized bench comparing timer_sequencer bus traffic and status against a transaction-level model.
module tb_timer_sequencer;
  localparam int MIN_PERIOD = 3;
  logic clk = 0, reset = 1, cfg_start = 0, cfg_abort = 0, timer_irq = 0;
  logic [31:0] cfg_period = 0;
  logic [15:0] cfg_count = 0, av_readdata, av_writedata, tick_count;
  logic [2:0] av_address;
  logic av_chipselect, av_write_n, busy, tick, done, err;
  logic slave_ok = 1, slave_run;
  logic [19:0] bus_q[$];
  int tick_seen = 0, done_seen = 0, vectors = 0, miscompares = 0;

  timer_sequencer #(.MIN_PERIOD(MIN_PERIOD)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_period(cfg_period), .cfg_count(cfg_count), .av_address(av_address),
    .av_chipselect(av_chipselect), .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .timer_irq(timer_irq), .busy(busy), .tick(tick),
    .tick_count(tick_count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      slave_run <= 1'b0;
      av_readdata <= 16'h0;
    end else begin
      if (av_chipselect && !av_write_n && av_address == 3'd1) slave_run <= av_writedata[2] && !av_writedata[3];
      av_readdata <= (av_chipselect && av_write_n && av_address == 3'd0) ? {14'h0, slave_run && slave_ok, 1'b0} : 16'h0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (av_chipselect) bus_q.push_back({!av_write_n, av_address, av_write_n ? 16'h0 : av_writedata});
      tick_seen += int'(tick);
      done_seen += int'(done);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // mode 0: auto-stop or plain abort, 1: irq and abort together in RUN, 2: abort during CLR, 3: abort in WR_PL
  task automatic run(input logic [31:0] p, input logic [15:0] c, input int n, input int mode, input bit ok, input bit poke);
    logic [19:0] exp[$];
    logic [31:0] pc;
    int b, t0, d0, ticks;
    pc = p < MIN_PERIOD ? 32'(MIN_PERIOD) : p;
    b = bus_q.size(); t0 = tick_seen; d0 = done_seen; ticks = 0;
    slave_ok = ok;
    exp.push_back({1'b1, 3'd2, pc[15:0]});
    @(negedge clk);
    cfg_start = 1; cfg_period = p; cfg_count = c;
    @(negedge clk);
    cfg_start = 0; cfg_period = $urandom; cfg_count = 16'($urandom);
    check("start_lat", {av_chipselect, av_write_n, av_address, av_writedata}, {1'b1, 1'b0, 3'd2, pc[15:0]});
    check("start_state", {busy, err, tick_count}, {1'b1, 1'b0, 16'h0});
    if (mode == 3) begin
      cfg_abort = 1;
      @(negedge clk);
      cfg_abort = 0;
    end else begin
      exp.push_back({1'b1, 3'd3, pc[31:16]});
      exp.push_back({1'b1, 3'd1, 16'h0007});
      exp.push_back({1'b0, 3'd0, 16'h0000});
      repeat (5) @(negedge clk);
      if (ok) begin
        for (int i = 0; i < n; i++) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          if (poke && i == 0) begin
            cfg_start = 1; cfg_period = 32'h5; cfg_count = 16'h1;
            @(negedge clk);
            cfg_start = 0;
          end
          timer_irq = 1;
          @(negedge clk);
          check("irq_lat", {tick, av_chipselect, av_write_n, av_address, av_writedata}, {1'b1, 1'b1, 1'b0, 3'd0, 16'h0});
          timer_irq = 0;
          exp.push_back({1'b1, 3'd0, 16'h0});
          ticks++;
        end
        if (c == 0) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          if (mode == 1) begin
            cfg_abort = 1; timer_irq = 1;
            @(negedge clk);
            check("abort_irq_notick", tick, 0);
            cfg_abort = 0; timer_irq = 0;
          end else if (mode == 2) begin
            timer_irq = 1;
            @(negedge clk);
            cfg_abort = 1; timer_irq = 0;
            check("abort_clr_tick", tick, 1);
            exp.push_back({1'b1, 3'd0, 16'h0});
            ticks++;
            @(negedge clk);
            cfg_abort = 0;
          end else begin
            cfg_abort = 1;
            @(negedge clk);
            cfg_abort = 0;
          end
        end
      end
    end
    exp.push_back({1'b1, 3'd1, 16'h0008});
    for (int k = 0; k < 30 && !done; k++) @(negedge clk);
    check("done", done, 1);
    repeat (3) @(negedge clk);
    check("done_once", done_seen - d0, 1);
    check("busy_end", busy, 0);
    check("err", err, !ok);
    check("tick_count", tick_count, ticks);
    check("tick_pulses", tick_seen - t0, ticks);
    check("bus_len", bus_q.size() - b, exp.size());
    for (int i = 0; i < exp.size() && b + i < bus_q.size(); i++) check($sformatf("bus%0d", i), bus_q[b + i], exp[i]);
  endtask

  initial begin
    int b, mode, n;
    logic [15:0] c;
    logic [31:0] p;
    repeat (3) @(negedge clk);
    check("reset_bus", {av_chipselect, av_write_n, av_address, av_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
    check("reset_stat", {busy, tick, tick_count, done, err}, {1'b0, 1'b0, 16'h0, 1'b0, 1'b0});
    reset = 0;
    @(negedge clk);
    run(32'd99, 16'd3, 3, 0, 1, 0);
    run(32'h0001_86A0, 16'd0, 5, 0, 1, 0);
    run(32'd200, 16'd2, 2, 0, 0, 0);
    run(32'd10, 16'd1, 1, 0, 1, 0);
    run(32'd1, 16'd2, 2, 0, 1, 1);
    run(32'd40, 16'd0, 2, 1, 1, 0);
    run(32'd40, 16'd0, 1, 2, 1, 0);
    run(32'd77, 16'd0, 0, 3, 1, 0);
    b = bus_q.size();
    @(negedge clk);
    cfg_start = 1; cfg_period = 32'd50; cfg_count = 16'd0;
    @(negedge clk);
    cfg_start = 0;
    repeat (5) @(negedge clk);
    timer_irq = 1;
    @(negedge clk);
    timer_irq = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("rst_run_bus", {av_chipselect, av_write_n, av_address, av_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
    check("rst_run_stat", {busy, tick, tick_count, done, err}, {1'b0, 1'b0, 16'h0, 1'b0, 1'b0});
    reset = 0;
    repeat (3) @(negedge clk);
    check("rst_no_stop", bus_q.size() - b, 5);
    check("rst_idle", busy, 0);
    for (int r = 0; r < 12; r++) begin
      mode = $urandom_range(0, 3);
      p = $urandom_range(0, 1) ? 32'($urandom_range(0, 5)) : $urandom;
      c = 16'd0;
      n = $urandom_range(0, 4);
      if (mode == 0 && $urandom_range(0, 1) == 1) begin
        c = 16'($urandom_range(1, 4));
        n = int'(c);
      end
      run(p, c, n, mode, mode == 3 || $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
